cart_access_arbiter: RTL and testbench

- Shares the emulated cartridge port (banks 00/01, 8000h-FFFFh, ROM behind synchronous block RAM) between two requesters: CPU (port 0) and general-purpose DMA (port 1).
- Picks one request at a time and drives the cartridge address/strobe signals. Waits out the memory read latency, then returns the data with a one-cycle acknowledge.
- Sits between the bus-master mux and the cartridge module.
- Also supplies open-bus data for unmapped addresses.

---
 rtl/cart_access_arbiter_pkg.sv | 35 +++
 rtl/cart_arb_priority.sv | 44 ++++
 rtl/cart_access_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cart_access_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_access_arbiter_pkg.sv
// Shared types and constants for the cartridge access arbiter.
package cart_access_arbiter_pkg;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned CNT_W    = 3;

  // Requester indices
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Cartridge window: banks 00/01 only, upper half of each bank
  localparam logic [ADDR_W-1:0] CART_BANK_MASK = 24'hFE_0000;
  localparam int unsigned       CART_SEL_BIT   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } cart_req_t;

  // True when the address decodes to the cartridge ROM window
  function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
    return ((addr & CART_BANK_MASK) == '0) && addr[CART_SEL_BIT];
  endfunction

endpackage

// File: rtl/cart_arb_priority.sv
// Winner select (DMA first, CPU forced through after MAX_STARVE) plus starve counter.
module cart_arb_priority
  import cart_access_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic grant_i,
  output logic win_dma_c
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starve_full_c;
  logic                cpu_wins_c;

  assign starve_full_c = (starve_q == STARVE_W'(MAX_STARVE));
  assign cpu_wins_c    = cpu_req_i && (!dma_req_i || starve_full_c);
  assign win_dma_c     = !cpu_wins_c;

  // Count DMA grants that bypass a pending CPU; any CPU grant clears the count
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      if (cpu_wins_c) begin
        starve_d = '0;
      end else if (cpu_req_i && !starve_full_c) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Starve counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/cart_access_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the cartridge ROM, with open-bus reads.
module cart_access_arbiter
  import cart_access_arbiter_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_write,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] a_addr,
  output logic              a_read,
  output logic              a_write,
  output logic              cart_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  arb_state_t        state_q, state_d;
  logic              win_q, win_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] open_bus_q, open_bus_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
  logic              a_read_q, a_read_d;
  logic              a_write_q, a_write_d;
  logic              cart_en_q, cart_en_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;

  logic              grant_c;
  logic              win_dma_c;
  logic              enter_resp_c;
  cart_req_t         win_pl_c;

  assign grant_c  = (state_q == IDLE) && (cpu_req || dma_req);
  assign win_pl_c = win_dma_c ? cart_req_t'{dma_addr, dma_write, dma_wdata}
                              : cart_req_t'{cpu_addr, cpu_write, cpu_wdata};

  cart_arb_priority #(
    .MAX_STARVE (MAX_STARVE)
  ) u_prio (
    .clk       (clk),
    .reset     (reset),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .grant_i   (grant_c),
    .win_dma_c (win_dma_c)
  );

  // Next-state and registered-output logic; strobes are loaded on entry to ISSUE
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    open_bus_d   = open_bus_q;
    a_addr_d     = a_addr_q;
    wdata_d      = wdata_q;
    rdata_out_d  = rdata_out_q;
    a_read_d     = 1'b0;
    a_write_d    = 1'b0;
    cart_en_d    = 1'b0;
    enter_resp_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_c) begin
          win_d   = win_dma_c ? REQ_DMA : REQ_CPU;
          write_d = win_pl_c.write;
          if (is_mapped(win_pl_c.addr)) begin
            state_d   = ISSUE;
            a_addr_d  = win_pl_c.addr;
            wdata_d   = win_pl_c.wdata;
            cart_en_d = 1'b1;
            a_read_d  = !win_pl_c.write;
            a_write_d = win_pl_c.write;
          end else begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
            rdata_out_d  = open_bus_q;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
          rdata_out_d  = open_bus_q;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
          open_bus_d   = rdata;
          rdata_out_d  = rdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_ack_d = enter_resp_c && (win_d == REQ_CPU);
    dma_ack_d = enter_resp_c && (win_d == REQ_DMA);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= REQ_CPU;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      open_bus_q  <= '0;
      a_addr_q    <= '0;
      wdata_q     <= '0;
      rdata_out_q <= '0;
      a_read_q    <= 1'b0;
      a_write_q   <= 1'b0;
      cart_en_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      open_bus_q  <= open_bus_d;
      a_addr_q    <= a_addr_d;
      wdata_q     <= wdata_d;
      rdata_out_q <= rdata_out_d;
      a_read_q    <= a_read_d;
      a_write_q   <= a_write_d;
      cart_en_q   <= cart_en_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign a_addr    = a_addr_q;
  assign wdata     = wdata_q;
  assign rdata_out = rdata_out_q;
  assign a_read    = a_read_q;
  assign a_write   = a_write_q;
  assign cart_en   = cart_en_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_cart_access_arbiter.sv
// Self-checking bench for cart_access_arbiter: vector table, corner sequences, random vs model.
module tb_cart_access_arbiter;

  localparam int L  = 3;
  localparam int MS = 4;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_write, dma_req, dma_write;
  logic [23:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack;
  logic [7:0]  rdata_out, wdata, rdata;
  logic [23:0] a_addr;
  logic        a_read, a_write, cart_en;

  cart_access_arbiter #(.RD_LATENCY(L), .MAX_STARVE(MS)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_write(dma_write), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack),
    .rdata_out(rdata_out), .a_addr(a_addr), .a_read(a_read), .a_write(a_write),
    .cart_en(cart_en), .wdata(wdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents chosen so that 008123h -> 5Ah and 0080DDh -> A5h
  function automatic logic [7:0] rom(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'b0} ^ 8'hF8;
  endfunction

  function automatic logic m_mapped(input logic [23:0] a);
    return (a < 24'h02_0000) && a[15];
  endfunction

  function automatic logic [23:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom);
      1:       return {7'b0, 1'($urandom), 1'b0, 15'($urandom)};
      default: return {7'b0, 1'($urandom), 1'b1, 15'($urandom)};
    endcase
  endfunction

  // Synchronous ROM with L cycles of read latency; garbage when not strobed
  logic [7:0] pipe [L];
  always_ff @(posedge clk) begin
    pipe[0] <= a_read ? rom(a_addr) : 8'hEE;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[L-1];

  // Bus monitor: strobe/ack bookkeeping and protocol violations
  int          n_rd = 0, n_wr = 0, n_ack = 0, bad = 0;
  logic [23:0] st_addr = '0;
  logic [7:0]  st_wdata = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (a_read) begin n_rd <= n_rd + 1; st_addr <= a_addr; end
      if (a_write) begin n_wr <= n_wr + 1; st_addr <= a_addr; st_wdata <= wdata; end
      if (cpu_ack || dma_ack) n_ack <= n_ack + 1;
      if ((a_read && a_write) || (cart_en != (a_read || a_write)) || (cpu_ack && dma_ack))
        bad <= bad + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dma;
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wd;
    int          lat;
    logic [7:0]  rd;
    int          n_rd;
    int          n_wr;
  } vec_t;

  // Single request from one port, checked for latency, data and strobes
  task automatic run_txn(input vec_t v);
    int   b_rd, b_wr, cyc;
    logic got;
    repeat (2) @(negedge clk);
    b_rd = n_rd; b_wr = n_wr; cyc = 0; got = 1'b0;
    if (v.is_dma) begin
      dma_req = 1'b1; dma_addr = v.addr; dma_write = v.wr; dma_wdata = v.wd;
    end else begin
      cpu_req = 1'b1; cpu_addr = v.addr; cpu_write = v.wr; cpu_wdata = v.wd;
    end
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (cpu_ack || dma_ack) got = 1'b1;
    end
    chk("ack_seen", 64'(got), 1);
    chk("ack_src", {cpu_ack, dma_ack}, v.is_dma ? 2'b01 : 2'b10);
    chk("latency", 64'(cyc), 64'(v.lat));
    chk("rdata_out", rdata_out, v.rd);
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk); #1;
    chk("n_read_strobes", 64'(n_rd - b_rd), 64'(v.n_rd));
    chk("n_write_strobes", 64'(n_wr - b_wr), 64'(v.n_wr));
    if (v.n_rd + v.n_wr > 0) chk("strobe_addr", st_addr, v.addr);
    if (v.n_wr > 0) chk("strobe_wdata", st_wdata, v.wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [10];
    int          ng, cyc, last, b_ack, b_rd;
    logic        got;
    int          starve_m, ack_edge, next_free, lat;
    logic        cpu_p, dma_p, win_dma_m, tw;
    logic [23:0] ta;
    logic [7:0]  ob_m, exp_rd;

    reset = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cpu_write = 1'b0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; dma_write = 1'b0; dma_wdata = '0;

    tbl[0] = '{1'b0, 24'h008123, 1'b0, 8'h00, 2+L, 8'h5A, 1, 0};
    tbl[1] = '{1'b1, 24'h0080DD, 1'b0, 8'h00, 2+L, 8'hA5, 1, 0};
    tbl[2] = '{1'b1, 24'h7E0000, 1'b0, 8'h00, 1,   8'hA5, 0, 0};
    tbl[3] = '{1'b0, 24'h01FFFF, 1'b1, 8'h33, 2,   8'hA5, 0, 1};
    tbl[4] = '{1'b0, 24'h028000, 1'b0, 8'h00, 1,   8'hA5, 0, 0};
    tbl[5] = '{1'b1, 24'h007FFF, 1'b0, 8'h00, 1,   8'hA5, 0, 0};
    tbl[6] = '{1'b0, 24'h01FFFF, 1'b0, 8'h00, 2+L, 8'h78, 1, 0};
    tbl[7] = '{1'b1, 24'h7E0000, 1'b0, 8'h00, 1,   8'h78, 0, 0};
    tbl[8] = '{1'b1, 24'h008000, 1'b1, 8'hC3, 2,   8'h78, 0, 1};
    tbl[9] = '{1'b0, 24'hFF8000, 1'b1, 8'h11, 1,   8'h78, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {a_addr, wdata, rdata_out, a_read, a_write, cart_en, cpu_ack, dma_ack}, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Contention: both held, DMA wins MS times then CPU is forced through
    repeat (2) @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 24'h008123; cpu_write = 1'b0;
    dma_req = 1'b1; dma_addr = 24'h7E0000; dma_write = 1'b0;
    ng = 0; cyc = 0;
    while (ng < MS + 1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cpu_ack || dma_ack) begin
        chk($sformatf("contend_grant%0d", ng), {cpu_ack, dma_ack}, (ng == MS) ? 2'b10 : 2'b01);
        if (cpu_ack) chk("contend_cpu_rdata", rdata_out, 8'h5A);
        ng++;
        if (ng == MS + 1) begin cpu_req = 1'b0; dma_req = 1'b0; end
      end
    end
    chk("contend_grants", 64'(ng), 64'(MS + 1));
    chk("starve_after_cpu", 64'(dut.u_prio.starve_q), 0);

    // Reset in the middle of a DMA read's WAIT phase
    repeat (2) @(negedge clk);
    b_ack = n_ack;
    dma_req = 1'b1; dma_addr = 24'h008123; dma_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; dma_req = 1'b0;
    #1;
    chk("midwait_reset_outputs", {a_addr, wdata, rdata_out, a_read, a_write, cart_en, cpu_ack, dma_ack}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midwait_no_ack", 64'(n_ack - b_ack), 0);
    run_txn('{1'b1, 24'h7E0000, 1'b0, 8'h00, 1, 8'h00, 0, 0});
    run_txn('{1'b0, 24'h0080DD, 1'b0, 8'h00, 2+L, 8'hA5, 1, 0});

    // Back-to-back CPU reads with req held high throughout
    repeat (2) @(negedge clk);
    b_rd = n_rd;
    cpu_req = 1'b1; cpu_addr = 24'h018000; cpu_write = 1'b0;
    cyc = 0; last = 0;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      while (!got && cyc < 100) begin
        @(posedge clk); #1; cyc++;
        if (cpu_ack) got = 1'b1;
      end
      chk("b2b_ack", 64'(got), 1);
      chk("b2b_rdata", rdata_out, 8'(8'hF8 + i));
      chk("b2b_spacing", 64'(cyc - last), (i == 0) ? 64'(2 + L) : 64'(3 + L));
      last = cyc;
      if (i < 2) cpu_addr = cpu_addr + 24'd1;
      else cpu_req = 1'b0;
    end
    @(negedge clk); #1;
    chk("b2b_strobes", 64'(n_rd - b_rd), 3);

    // Random traffic against a transaction-level model
    @(negedge clk);
    starve_m = 0; ack_edge = -1; next_free = 0; lat = 0;
    cpu_p = 1'b0; dma_p = 1'b0; win_dma_m = 1'b0; ob_m = 8'hFA; exp_rd = 8'h00;
    for (int e = 0; e < 400; e++) begin
      if (!cpu_p && $urandom_range(0, 2) == 0) begin
        cpu_p = 1'b1; cpu_req = 1'b1; cpu_addr = rand_addr();
        cpu_write = 1'($urandom); cpu_wdata = 8'($urandom);
      end
      if (!dma_p && $urandom_range(0, 2) == 0) begin
        dma_p = 1'b1; dma_req = 1'b1; dma_addr = rand_addr();
        dma_write = 1'($urandom); dma_wdata = 8'($urandom);
      end
      if (e == next_free) begin
        if (cpu_p || dma_p) begin
          win_dma_m = !(cpu_p && (!dma_p || starve_m == MS));
          if (win_dma_m) begin
            ta = dma_addr; tw = dma_write;
            if (cpu_p && starve_m < MS) starve_m++;
          end else begin
            ta = cpu_addr; tw = cpu_write; starve_m = 0;
          end
          if (!m_mapped(ta)) lat = 1;
          else if (tw) lat = 2;
          else lat = 2 + L;
          if (m_mapped(ta) && !tw) ob_m = rom(ta);
          exp_rd = ob_m;
          ack_edge = e + lat - 1;
          next_free = e + lat + 1;
        end else begin
          next_free = e + 1;
        end
      end
      @(posedge clk); #1;
      chk("rand_ack", {cpu_ack, dma_ack}, (e == ack_edge) ? (win_dma_m ? 2'b01 : 2'b10) : 2'b00);
      if (e == ack_edge) begin
        chk("rand_rdata", rdata_out, exp_rd);
        if (win_dma_m) begin dma_p = 1'b0; dma_req = 1'b0; end
        else begin cpu_p = 1'b0; cpu_req = 1'b0; end
      end
      @(negedge clk);
    end

    chk("protocol_violations", 64'(bad), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
